// File: rtl/full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// Registered ripple-carry adder built from 1-bit full-adder cells. Each cell
// is two half adders followed by an OR of their carries. With the default
// WIDTH=1 this is the classic 1-bit full adder.
//
// Parameters:
//   WIDTH     operand width in bits (1..64)
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   in_valid  operands valid this cycle; result captured when high
//   a, b      unsigned operands, WIDTH bits
//   cin       carry-in to bit 0
//   sum       registered sum, WIDTH bits
//   cout      registered carry-out of the MSB
//   out_valid high for one cycle when sum/cout hold a new result
//
// Latency is one clock. sum/cout hold their value on cycles without
// in_valid, so X on the operands while idle never reaches the outputs.
// ---------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    // Carry chain: c[0] is the carry-in, c[WIDTH] the carry-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] p;   // half adder 1 sum (propagate)
    logic [WIDTH-1:0] g1;  // half adder 1 carry (generate)
    logic [WIDTH-1:0] s;   // half adder 2 sum (cell sum)
    logic [WIDTH-1:0] g2;  // half adder 2 carry

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        // Half adder 1 on the operand bits.
        assign p[i]   = a[i] ^ b[i];
        assign g1[i]  = a[i] & b[i];
        // Half adder 2 folds in the incoming carry.
        assign s[i]   = p[i] ^ c[i];
        assign g2[i]  = p[i] & c[i];
        // At most one of g1/g2 can be high, so OR forms the carry-out.
        assign c[i+1] = g1[i] | g2[i];
    end

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= s;
            cout      <= c[WIDTH];
            out_valid <= 1'b1;
        end else begin
            // NOTE: leaving sum/cout unassigned in a clocked block infers a
            // load-enable flop (a hold), not a latch; only out_valid drops.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// ---------------------------------------------------------------------------
// tb_full_adder
//
// Drives two instances of full_adder (WIDTH=1 and WIDTH=8) from a shared
// clock and reset. Each driven cycle pushes an expectation entry per DUT;
// a monitor pops one entry per DUT just after every rising edge, tracks the
// value the outputs should hold, and compares out_valid and {cout,sum}.
// ---------------------------------------------------------------------------
module tb_full_adder;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [8:0] res;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       out_valid1;

    logic       in_valid8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       out_valid8;

    entry_t     q1[$];
    entry_t     q8[$];
    entry_t     e1;
    entry_t     e8;
    logic [8:0] held1 = '0;
    logic [8:0] held8 = '0;

    int checks   = 0;
    int failures = 0;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sum       (sum1),
        .cout      (cout1),
        .out_valid (out_valid1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sum       (sum8),
        .cout      (cout8),
        .out_valid (out_valid8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One driven cycle: apply inputs on the falling edge and record what
    // each DUT should show after the following rising edge.
    task automatic step(input logic r,
                        input logic v1, input logic x1, input logic y1,
                        input logic c1,
                        input logic v8, input logic [7:0] x8,
                        input logic [7:0] y8, input logic c8);
        entry_t n1;
        entry_t n8;
        @(negedge clk);
        rst       = r;
        in_valid1 = v1;
        a1        = x1;
        b1        = y1;
        cin1      = c1;
        in_valid8 = v8;
        a8        = x8;
        b8        = y8;
        cin8      = c8;
        n1.rst = r;
        n1.vld = v1 && !r;
        n1.res = 9'(x1) + 9'(y1) + 9'(c1);
        n8.rst = r;
        n8.vld = v8 && !r;
        n8.res = 9'(x8) + 9'(y8) + 9'(c8);
        q1.push_back(n1);
        q8.push_back(n8);
    endtask

    // Monitor: sample #1 after the rising edge, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            if (e1.rst)      held1 = '0;
            else if (e1.vld) held1 = e1.res;
            check("w1_out_valid", 64'(out_valid1), 64'(e1.vld));
            check("w1_cout_sum", 64'({cout1, sum1}), 64'(held1));
        end
        if (q8.size() > 0) begin
            e8 = q8.pop_front();
            if (e8.rst)      held8 = '0;
            else if (e8.vld) held8 = e8.res;
            check("w8_out_valid", 64'(out_valid8), 64'(e8.vld));
            check("w8_cout_sum", 64'({cout8, sum8}), 64'(held8));
        end
    end

    initial begin
        logic [2:0] abc;
        // Reset for two cycles with valid operands present: nothing escapes.
        repeat (2) step(1, 1, 1, 1, 1, 1, 8'h01, 8'h01, 1);

        // Exhaustive 1-bit truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            step(0, 1, abc[2], abc[1], abc[0], 0, 8'h00, 8'h00, 0);
        end

        // Hold: capture 1+1+0, then idle with different operands.
        step(0, 1, 1, 1, 0, 1, 8'h01, 8'h01, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1);

        // Reset mid-operation discards the operand, then normal operation.
        step(1, 1, 1, 0, 0, 1, 8'h01, 8'h00, 0);
        step(0, 1, 1, 0, 0, 1, 8'h01, 8'h00, 0);

        // 8-bit carry ripple and boundary cases.
        step(0, 0, 0, 0, 0, 1, 8'hFF, 8'h00, 1);
        step(0, 0, 0, 0, 0, 1, 8'h80, 8'h80, 0);
        step(0, 0, 0, 0, 0, 1, 8'h5A, 8'h25, 1);
        step(0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
        step(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0);
        step(0, 0, 0, 0, 0, 0, 8'h12, 8'h34, 0);

        // Random traffic with random valid on both widths.
        for (int i = 0; i < 1000; i++) begin
            step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        // Let the final expectations drain through the monitor.
        @(negedge clk);
        in_valid1 = 1'b0;
        in_valid8 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", 64'(q1.size() + q8.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
